param_node: RTL and testbench
=============================

Name: param_node

Overview:
- Parametrised endpoint node between the testbench packet interface and the router link; successor to the fixed 8-bit, single-width node.
- Outbound: buffers 32-bit pkt_t packets in a queue of Q_DEPTH entries, then serialises each into PHIT_W-bit phits using the free/put handshake.
- Inbound: deserialises phits from the router and presents a whole packet to the testbench.
- Adds parametrised phit width and queue depth, a drop indication on overflow, and optional traffic counters.

Parameters:
- PHIT_W, 8, link phit width; legal values 4, 8, 16, 32. Localparam N_PHITS = 32/PHIT_W.
- Q_DEPTH, 4, outbound queue entries; power of 2, at least 2.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pkt_in  in  32  pkt_t from the testbench.
- pkt_in_avail  in  1  pkt_in is valid this cycle; enqueue request.
- cQ_full  out  1  queue holds Q_DEPTH packets.
- pkt_in_drop  out  1  one-cycle pulse: pkt_in_avail arrived while full, so the packet was discarded.
- free_outbound  in  1  router can accept one whole packet.
- put_outbound  out  1  phit valid on payload_outbound.
- payload_outbound  out  PHIT_W  outbound phit.
- put_inbound  in  1  phit valid on payload_inbound.
- payload_inbound  in  PHIT_W  inbound phit.
- free_inbound  out  1  node can accept one whole packet.
- pkt_out  out  32  assembled inbound pkt_t.
- pkt_out_avail  out  1  one-cycle pulse: pkt_out is valid.

Behaviour:
- Reset values: cQ_full=0, pkt_in_drop=0, put_outbound=0, payload_outbound=0, free_inbound=1, pkt_out=0, pkt_out_avail=0. Queue is emptied and both FSMs go to idle.
- Reset mid-operation: any partly sent or partly received packet is abandoned; put_outbound drops immediately.
- Queue:
  - cQ_full = (count==Q_DEPTH), combinational from the count.
  - Push on pkt_in_avail && !cQ_full.
  - pkt_in_avail && cQ_full: no push; pkt_in_drop=1 in the next cycle. This holds even if a pop occurs in the same cycle.
  - A pop and a push in the same cycle on a non-full queue leave the count unchanged.
  - Read/write pointers wrap modulo Q_DEPTH.
- Outbound FSM, states TX_IDLE and TX_SEND:
  - TX_IDLE → TX_SEND when queue non-empty && free_outbound. At that edge: pop the head into the shift register, cnt=0.
  - TX_SEND: put_outbound=1. payload_outbound = most-significant PHIT_W bits of the shift register, so phit 0 carries bits 31:32-PHIT_W (sourceID first). Shift left by PHIT_W each cycle.
  - Exit to TX_IDLE after N_PHITS consecutive put cycles. free_outbound is ignored while in TX_SEND.
  - At least one TX_IDLE cycle separates consecutive packets.
  - Latency: pkt_in_avail in cycle t, empty queue, free_outbound=1 in cycle t+1 → first put in cycle t+2, last put in cycle t+1+N_PHITS.
- Inbound FSM, states RX_IDLE and RX_RECV:
  - RX_IDLE: free_inbound=1. put_inbound captures phit 0 into the top of the assembly register; go to RX_RECV with cnt=1.
  - RX_RECV: free_inbound=0. Each put_inbound captures the next lower phit and increments cnt. Cycles with put_inbound=0 are wait cycles: no capture, no timeout.
  - On capture of phit N_PHITS-1: register pkt_out, pulse pkt_out_avail in the next cycle, return to RX_IDLE. free_inbound=1 in the same cycle as pkt_out_avail.
  - PHIT_W=32: single-phit packets. RX_RECV is never entered; pkt_out_avail follows the put by one cycle.
  - pkt_out holds its value until the next packet completes.
- The outbound and inbound paths are fully independent and may be active in the same cycle.

Optional Feature:
- Macro NODE_STATS_EN.
- Defined: adds outputs tx_pkt_cnt[15:0], rx_pkt_cnt[15:0], drop_cnt[15:0].
  - tx_pkt_cnt increments on TX_SEND exit.
  - rx_pkt_cnt increments with each pkt_out_avail.
  - drop_cnt increments with each pkt_in_drop.
  - All three reset to 0, wrap 0xFFFF→0, and may increment together in one cycle.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package node_pkg holds:
  - pkt_t (sourceID[3:0], destID[3:0], data[23:0], packed 32 bits);
  - PKT_W=32;
  - the tx/rx state enums.
- Sub-module pkt_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) implements the outbound queue. Both serdes FSMs live in param_node.

Test Plan:
- PHIT_W=8, free_outbound=1, pkt_in=0x12ABCDEF pushed at cycle 0 → put_outbound high cycles 2–5; payloads 0x12, 0xAB, 0xCD, 0xEF.
- Q_DEPTH=4, free_outbound=0, five consecutive pushes → cQ_full=1 after the fourth; fifth gives pkt_in_drop pulse. Raising free sends the first four in order, with one idle cycle between packets.
- PHIT_W=4, router puts 0x3,0x5,0x0,0x0,0x0,0x0,0x7,0xF with two wait cycles mid-packet → free_inbound=0 during reception; pkt_out=0x3500007F with a single pkt_out_avail one cycle after the last put.
- PHIT_W=16, inbound and outbound packets overlap in time → both complete correctly.
- rst asserted during the second of four outbound phits → put_outbound=0 immediately, queue empty, free_inbound=1. A new push afterwards sends a complete packet.
- NODE_STATS_EN: 3 sent, 2 received, 1 dropped → tx/rx/drop counters read 3/2/1.

Source files
------------

// File: rtl/param_node_pkg.sv
`default_nettype none
// ============================================================================
// Package     : node_pkg
// Description : Shared types for the parametrised endpoint node: the 32-bit
//               packet layout and the outbound/inbound serdes state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package node_pkg;

    localparam int PKT_W = 32;

    // sourceID occupies the top nibble, so it is the first phit on the link.
    typedef struct packed {
        logic [3:0]  source_id;
        logic [3:0]  dest_id;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pkt_fifo
// Description : Circular-buffer packet queue. Pushes are ignored while full,
//               pops are ignored while empty; the head entry is always
//               visible on o_pop_data.
// Ports       : clk, rst (async, active high)
//               i_push / i_push_data  - enqueue request and data
//               i_pop                 - dequeue request
//               o_pop_data            - current head entry
//               o_full / o_empty      - occupancy flags
//               o_count               - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed behind count_q.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    assign o_pop_data = mem_q[rd_ptr_q];
    assign o_full     = (count_q == CNT_W'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;

endmodule
`default_nettype wire

// File: rtl/param_node.sv
`default_nettype none
// ============================================================================
// Module      : param_node
// Description : Endpoint node between the packet interface and a router
//               link. Outbound packets are queued and serialised MSB-first
//               into PHIT_W-bit phits; inbound phits are reassembled into a
//               packet. The two directions run independently.
// Parameters  : PHIT_W  - link phit width (4, 8, 16 or 32)
//               Q_DEPTH - outbound queue entries (power of two, >= 2)
// Ports       : clk, rst (async, active high)
//               pkt_in, pkt_in_avail, cQ_full, pkt_in_drop  - packet ingress
//               free_outbound, put_outbound, payload_outbound - link out
//               put_inbound, payload_inbound, free_inbound    - link in
//               pkt_out, pkt_out_avail                        - packet egress
// Options     : NODE_STATS_EN adds tx_pkt_cnt, rx_pkt_cnt, drop_cnt
//               (16-bit wrapping traffic counters).
// Revision    : 1.0 - initial release
// ============================================================================
module param_node
    import node_pkg::*;
#(
    parameter int PHIT_W  = 8,
    parameter int Q_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pkt_in,
    input  logic              pkt_in_avail,
    output logic              cQ_full,
    output logic              pkt_in_drop,
    input  logic              free_outbound,
    output logic              put_outbound,
    output logic [PHIT_W-1:0] payload_outbound,
    input  logic              put_inbound,
    input  logic [PHIT_W-1:0] payload_inbound,
    output logic              free_inbound,
    output logic [31:0]       pkt_out,
    output logic              pkt_out_avail
`ifdef NODE_STATS_EN
    ,
    output logic [15:0]       tx_pkt_cnt,
    output logic [15:0]       rx_pkt_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int N_PHITS = PKT_W / PHIT_W;
    localparam int CNT_W   = 6;
    localparam logic [CNT_W-1:0] LAST_PHIT = CNT_W'(N_PHITS - 1);
    localparam int QC_W    = $clog2(Q_DEPTH) + 1;

    // ---------------- outbound queue ----------------
    pkt_t             w_head;
    logic             w_q_full;
    logic             w_q_empty;
    logic [QC_W-1:0]  w_q_count;
    logic             w_tx_start;
    logic             w_tx_done;

    pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (pkt_in_avail),
        .i_push_data (pkt_in),
        .i_pop       (w_tx_start),
        .o_pop_data  (w_head),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty),
        .o_count     (w_q_count)
    );

    assign cQ_full = (w_q_count == QC_W'(Q_DEPTH));

    logic pkt_in_drop_q, pkt_in_drop_d;

    // A full queue drops the arrival even if a pop frees a slot this cycle.
    assign pkt_in_drop_d = pkt_in_avail && w_q_full;

    // ---------------- outbound serialiser ----------------
    tx_state_t        tx_state_q, tx_state_d;
    logic [PKT_W-1:0] tx_sr_q,    tx_sr_d;
    logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_sr_d    = tx_sr_q;
        tx_cnt_d   = tx_cnt_q;
        w_tx_start = 1'b0;
        w_tx_done  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!w_q_empty && free_outbound) begin
                    w_tx_start = 1'b1;
                    tx_sr_d    = w_head;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                tx_sr_d = tx_sr_q << PHIT_W;
                if (tx_cnt_q == LAST_PHIT) begin
                    w_tx_done  = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign put_outbound     = (tx_state_q == TX_SEND);
    assign payload_outbound = put_outbound ? tx_sr_q[PKT_W-1 -: PHIT_W] : '0;

    // ---------------- inbound deserialiser ----------------
    rx_state_t        rx_state_q, rx_state_d;
    logic [PKT_W-1:0] rx_sr_q,    rx_sr_d;
    logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [PKT_W-1:0] pkt_out_q,  pkt_out_d;
    logic             pkt_out_avail_q, pkt_out_avail_d;
    logic [PKT_W-1:0] w_rx_shift;

    // Phits enter at the bottom and move up, so phit 0 ends in the top bits.
    assign w_rx_shift = (rx_sr_q << PHIT_W) | PKT_W'(payload_inbound);

    always_comb begin
        rx_state_d      = rx_state_q;
        rx_sr_d         = rx_sr_q;
        rx_cnt_d        = rx_cnt_q;
        pkt_out_d       = pkt_out_q;
        pkt_out_avail_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (put_inbound) begin
                    if (N_PHITS == 1) begin
                        pkt_out_d       = PKT_W'(payload_inbound);
                        pkt_out_avail_d = 1'b1;
                    end else begin
                        rx_sr_d    = PKT_W'(payload_inbound);
                        rx_cnt_d   = CNT_W'(1);
                        rx_state_d = RX_RECV;
                    end
                end
            end
            RX_RECV: begin
                // put_inbound low is a wait cycle; there is no timeout.
                if (put_inbound) begin
                    if (rx_cnt_q == LAST_PHIT) begin
                        pkt_out_d       = w_rx_shift;
                        pkt_out_avail_d = 1'b1;
                        rx_state_d      = RX_IDLE;
                    end else begin
                        rx_sr_d  = w_rx_shift;
                        rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign free_inbound  = (rx_state_q == RX_IDLE);
    assign pkt_out       = pkt_out_q;
    assign pkt_out_avail = pkt_out_avail_q;
    assign pkt_in_drop   = pkt_in_drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q      <= TX_IDLE;
            tx_sr_q         <= '0;
            tx_cnt_q        <= '0;
            rx_state_q      <= RX_IDLE;
            rx_sr_q         <= '0;
            rx_cnt_q        <= '0;
            pkt_out_q       <= '0;
            pkt_out_avail_q <= 1'b0;
            pkt_in_drop_q   <= 1'b0;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_sr_q         <= tx_sr_d;
            tx_cnt_q        <= tx_cnt_d;
            rx_state_q      <= rx_state_d;
            rx_sr_q         <= rx_sr_d;
            rx_cnt_q        <= rx_cnt_d;
            pkt_out_q       <= pkt_out_d;
            pkt_out_avail_q <= pkt_out_avail_d;
            pkt_in_drop_q   <= pkt_in_drop_d;
        end
    end

`ifdef NODE_STATS_EN
    // ---------------- traffic counters ----------------
    logic [15:0] tx_pkt_cnt_q, tx_pkt_cnt_d;
    logic [15:0] rx_pkt_cnt_q, rx_pkt_cnt_d;
    logic [15:0] drop_cnt_q,   drop_cnt_d;

    always_comb begin
        tx_pkt_cnt_d = tx_pkt_cnt_q + (w_tx_done       ? 16'd1 : 16'd0);
        rx_pkt_cnt_d = rx_pkt_cnt_q + (pkt_out_avail_q ? 16'd1 : 16'd0);
        drop_cnt_d   = drop_cnt_q   + (pkt_in_drop_q   ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_pkt_cnt_q <= '0;
            rx_pkt_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            tx_pkt_cnt_q <= tx_pkt_cnt_d;
            rx_pkt_cnt_q <= rx_pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign tx_pkt_cnt = tx_pkt_cnt_q;
    assign rx_pkt_cnt = rx_pkt_cnt_q;
    assign drop_cnt   = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_node.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_node
// Description : Directed self-checking bench for param_node. Three instances:
//               PHIT_W=8/Q_DEPTH=4, PHIT_W=4/Q_DEPTH=2, PHIT_W=16/Q_DEPTH=4.
//               Counter checks are compiled in when NODE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_node;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst8;

    int vectors     = 0;
    int miscompares = 0;

    // ---------- PHIT_W = 8 instance ----------
    logic [31:0] pkt_in8, pkt_out8;
    logic        avail8, full8, drop8, free_o8, put_o8, put_i8, free_i8, avail_o8;
    logic [7:0]  pay_o8, pay_i8;

    // ---------- PHIT_W = 4 instance ----------
    logic [31:0] pkt_in4, pkt_out4;
    logic        avail4, full4, drop4, free_o4, put_o4, put_i4, free_i4, avail_o4;
    logic [3:0]  pay_o4, pay_i4;

    // ---------- PHIT_W = 16 instance ----------
    logic [31:0] pkt_in16, pkt_out16;
    logic        avail16, full16, drop16, free_o16, put_o16, put_i16, free_i16, avail_o16;
    logic [15:0] pay_o16, pay_i16;

`ifdef NODE_STATS_EN
    logic [15:0] txc8, rxc8, drc8, txc4, rxc4, drc4, txc16, rxc16, drc16;
`endif

    param_node #(.PHIT_W(8), .Q_DEPTH(4)) u8 (
        .clk(clk), .rst(rst8),
        .pkt_in(pkt_in8), .pkt_in_avail(avail8), .cQ_full(full8), .pkt_in_drop(drop8),
        .free_outbound(free_o8), .put_outbound(put_o8), .payload_outbound(pay_o8),
        .put_inbound(put_i8), .payload_inbound(pay_i8), .free_inbound(free_i8),
        .pkt_out(pkt_out8), .pkt_out_avail(avail_o8)
`ifdef NODE_STATS_EN
        , .tx_pkt_cnt(txc8), .rx_pkt_cnt(rxc8), .drop_cnt(drc8)
`endif
    );

    param_node #(.PHIT_W(4), .Q_DEPTH(2)) u4 (
        .clk(clk), .rst(rst),
        .pkt_in(pkt_in4), .pkt_in_avail(avail4), .cQ_full(full4), .pkt_in_drop(drop4),
        .free_outbound(free_o4), .put_outbound(put_o4), .payload_outbound(pay_o4),
        .put_inbound(put_i4), .payload_inbound(pay_i4), .free_inbound(free_i4),
        .pkt_out(pkt_out4), .pkt_out_avail(avail_o4)
`ifdef NODE_STATS_EN
        , .tx_pkt_cnt(txc4), .rx_pkt_cnt(rxc4), .drop_cnt(drc4)
`endif
    );

    param_node #(.PHIT_W(16), .Q_DEPTH(4)) u16 (
        .clk(clk), .rst(rst),
        .pkt_in(pkt_in16), .pkt_in_avail(avail16), .cQ_full(full16), .pkt_in_drop(drop16),
        .free_outbound(free_o16), .put_outbound(put_o16), .payload_outbound(pay_o16),
        .put_inbound(put_i16), .payload_inbound(pay_i16), .free_inbound(free_i16),
        .pkt_out(pkt_out16), .pkt_out_avail(avail_o16)
`ifdef NODE_STATS_EN
        , .tx_pkt_cnt(txc16), .rx_pkt_cnt(rxc16), .drop_cnt(drc16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks happen 2 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Push one packet into u8 with free_outbound high and check the full
    // serialisation: first put two cycles after the push, four byte phits.
    task automatic tx8_packet(input logic [31:0] v, input string tag);
        cyc(); avail8 = 1'b1; pkt_in8 = v; settle();
        check({tag, "_push_put"}, 32'(put_o8), 32'd0);
        cyc(); avail8 = 1'b0; settle();
        check({tag, "_wait_put"}, 32'(put_o8), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); settle();
            check($sformatf("%s_put%0d", tag, k), 32'(put_o8), 32'd1);
            check($sformatf("%s_pay%0d", tag, k), 32'(pay_o8), 32'(v[31-8*k -: 8]));
        end
        cyc(); settle();
        check({tag, "_end_put"}, 32'(put_o8), 32'd0);
    endtask

    logic [31:0] pk;
    logic [31:0] rxv;
    logic [3:0]  phits4 [8];

    initial begin
        rst = 1'b1; rst8 = 1'b1;
        pkt_in8 = '0;  avail8 = 1'b0;  free_o8 = 1'b0;  put_i8 = 1'b0;  pay_i8 = '0;
        pkt_in4 = '0;  avail4 = 1'b0;  free_o4 = 1'b0;  put_i4 = 1'b0;  pay_i4 = '0;
        pkt_in16 = '0; avail16 = 1'b0; free_o16 = 1'b0; put_i16 = 1'b0; pay_i16 = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; rst8 = 1'b0;
        settle();

        // ---------------- reset state ----------------
        check("rst_full",     32'(full8),    32'd0);
        check("rst_drop",     32'(drop8),    32'd0);
        check("rst_put",      32'(put_o8),   32'd0);
        check("rst_payload",  32'(pay_o8),   32'd0);
        check("rst_free_in",  32'(free_i8),  32'd1);
        check("rst_pkt_out",  pkt_out8,      32'd0);
        check("rst_out_av",   32'(avail_o8), 32'd0);
        check("rst_free_in4", 32'(free_i4),  32'd1);
        check("rst_pkt16",    pkt_out16,     32'd0);

        // ---------------- basic serialisation, PHIT_W=8 ----------------
        free_o8 = 1'b1;
        tx8_packet(32'h12AB_CDEF, "tx8a");

        // ---------------- overflow and ordered drain ----------------
        free_o8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); avail8 = 1'b1; pkt_in8 = 32'h1100_0001 + 32'(i); settle();
            check($sformatf("fill_full%0d", i), 32'(full8), 32'd0);
        end
        cyc(); pkt_in8 = 32'h1100_0005; settle();
        check("full_after4", 32'(full8), 32'd1);
        cyc(); avail8 = 1'b0; settle();
        check("drop_pulse",  32'(drop8), 32'd1);
        check("still_full",  32'(full8), 32'd1);
        cyc(); free_o8 = 1'b1; settle();
        check("drop_one_cycle", 32'(drop8),  32'd0);
        check("drain_start",    32'(put_o8), 32'd0);
        for (int p = 0; p < 4; p++) begin
            pk = 32'h1100_0001 + 32'(p);
            for (int k = 0; k < 4; k++) begin
                cyc(); settle();
                check($sformatf("drain%0d_put%0d", p, k), 32'(put_o8), 32'd1);
                check($sformatf("drain%0d_pay%0d", p, k), 32'(pay_o8), 32'(pk[31-8*k -: 8]));
            end
            cyc(); settle();
            check($sformatf("drain%0d_gap", p), 32'(put_o8), 32'd0);
        end
        check("drain_not_full", 32'(full8), 32'd0);

        // ---------------- inbound with wait cycles, PHIT_W=4 ----------------
        phits4 = '{4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'hF};
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                repeat (2) begin
                    cyc(); put_i4 = 1'b0; pay_i4 = 4'h0; settle();
                    check("rx4_wait_free", 32'(free_i4),  32'd0);
                    check("rx4_wait_av",   32'(avail_o4), 32'd0);
                end
            end
            cyc(); put_i4 = 1'b1; pay_i4 = phits4[k]; settle();
            check($sformatf("rx4_free%0d", k), 32'(free_i4), (k == 0) ? 32'd1 : 32'd0);
            check($sformatf("rx4_av%0d", k),   32'(avail_o4), 32'd0);
        end
        cyc(); put_i4 = 1'b0; pay_i4 = 4'h0; settle();
        check("rx4_avail",   32'(avail_o4), 32'd1);
        check("rx4_pkt_out", pkt_out4,      32'h3500_007F);
        check("rx4_free_bk", 32'(free_i4),  32'd1);
        cyc(); settle();
        check("rx4_av_pulse", 32'(avail_o4), 32'd0);
        check("rx4_hold",     pkt_out4,      32'h3500_007F);

        // back-to-back second packet
        rxv = 32'h1234_5678;
        for (int k = 0; k < 8; k++) begin
            cyc(); put_i4 = 1'b1; pay_i4 = rxv[31-4*k -: 4]; settle();
        end
        cyc(); put_i4 = 1'b0; settle();
        check("rx4b_avail", 32'(avail_o4), 32'd1);
        check("rx4b_pkt",   pkt_out4,      32'h1234_5678);

        // ---------------- overlap in/out, PHIT_W=16 ----------------
        free_o16 = 1'b1;
        cyc(); avail16 = 1'b1; pkt_in16 = 32'hA5A5_1234; settle();
        cyc(); avail16 = 1'b0; settle();
        cyc(); put_i16 = 1'b1; pay_i16 = 16'hBEEF; settle();
        check("ov_put0",  32'(put_o16),  32'd1);
        check("ov_pay0",  32'(pay_o16),  32'h0000_A5A5);
        check("ov_free0", 32'(free_i16), 32'd1);
        cyc(); pay_i16 = 16'h0042; settle();
        check("ov_put1",  32'(put_o16),  32'd1);
        check("ov_pay1",  32'(pay_o16),  32'h0000_1234);
        check("ov_free1", 32'(free_i16), 32'd0);
        cyc(); put_i16 = 1'b0; pay_i16 = '0; settle();
        check("ov_put_end", 32'(put_o16),   32'd0);
        check("ov_avail",   32'(avail_o16), 32'd1);
        check("ov_pkt",     pkt_out16,      32'hBEEF_0042);
        check("ov_free2",   32'(free_i16),  32'd1);

        // ---------------- small queue overflow, PHIT_W=4, Q_DEPTH=2 ----------------
        free_o4 = 1'b0;
        cyc(); avail4 = 1'b1; pkt_in4 = 32'h1111_1111; settle();
        check("q2_full0", 32'(full4), 32'd0);
        cyc(); pkt_in4 = 32'h2222_2222; settle();
        check("q2_full1", 32'(full4), 32'd0);
        cyc(); pkt_in4 = 32'h3333_3333; settle();
        check("q2_full2", 32'(full4), 32'd1);
        cyc(); avail4 = 1'b0; settle();
        check("q2_drop", 32'(drop4), 32'd1);
        cyc(); free_o4 = 1'b1; settle();
        check("q2_drop_end", 32'(drop4), 32'd0);
        for (int p = 0; p < 2; p++) begin
            pk = (p == 0) ? 32'h1111_1111 : 32'h2222_2222;
            for (int k = 0; k < 8; k++) begin
                cyc(); settle();
                check($sformatf("q2_%0d_put%0d", p, k), 32'(put_o4), 32'd1);
                check($sformatf("q2_%0d_pay%0d", p, k), 32'(pay_o4), 32'(pk[31-4*k -: 4]));
            end
            cyc(); settle();
            check($sformatf("q2_%0d_gap", p), 32'(put_o4), 32'd0);
        end
        pk = 32'h9ABC_DEF0;
        cyc(); avail4 = 1'b1; pkt_in4 = pk; settle();
        cyc(); avail4 = 1'b0; settle();
        check("tx4_wait", 32'(put_o4), 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(); settle();
            check($sformatf("tx4_put%0d", k), 32'(put_o4), 32'd1);
            check($sformatf("tx4_pay%0d", k), 32'(pay_o4), 32'(pk[31-4*k -: 4]));
        end
        cyc(); settle();
        check("tx4_end", 32'(put_o4), 32'd0);

`ifdef NODE_STATS_EN
        check("stat_tx",   32'(txc4), 32'd3);
        check("stat_rx",   32'(rxc4), 32'd2);
        check("stat_drop", 32'(drc4), 32'd1);
        check("stat_tx16", 32'(txc16), 32'd1);
`endif

        // ---------------- reset mid-packet, PHIT_W=8 ----------------
        free_o8 = 1'b1;
        cyc(); avail8 = 1'b1; pkt_in8 = 32'hDEAD_BEEF; settle();
        cyc(); pkt_in8 = 32'h0102_0304; settle();
        cyc(); avail8 = 1'b0; settle();
        check("mr_put0", 32'(put_o8), 32'd1);
        check("mr_pay0", 32'(pay_o8), 32'h0000_00DE);
        cyc(); settle();
        check("mr_put1", 32'(put_o8), 32'd1);
        check("mr_pay1", 32'(pay_o8), 32'h0000_00AD);
        rst8 = 1'b1;
        #1;
        check("mr_put_drop", 32'(put_o8),  32'd0);
        check("mr_pay_zero", 32'(pay_o8),  32'd0);
        check("mr_free_in",  32'(free_i8), 32'd1);
        check("mr_not_full", 32'(full8),   32'd0);
        cyc(); rst8 = 1'b0; settle();
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            check($sformatf("mr_empty%0d", i), 32'(put_o8), 32'd0);
        end
        tx8_packet(32'hCAFE_F00D, "tx8b");
`ifdef NODE_STATS_EN
        check("stat8_tx_after_rst", 32'(txc8), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
